// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: bit-slips a 20-bit raw window until control tokens
// repeat at a stable offset, then outputs aligned words with lock status.
module tmds_word_aligner #(
    parameter int unsigned SEARCH_CYCLES = 1024,
    parameter int unsigned LOCK_TOKENS   = 8,
    parameter int unsigned LOSS_CYCLES   = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] raw_word,
    output logic [9:0] aligned_word,
    output logic       control_token,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic       lock_lost
);

    localparam int unsigned TMAX = (SEARCH_CYCLES > LOSS_CYCLES) ? SEARCH_CYCLES : LOSS_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned RW   = $clog2(LOCK_TOKENS + 1);

    typedef enum logic [1:0] {HUNT, SLIP, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [9:0]    prev_q;
    logic [9:0]    word_q;
    logic          tok_q;
    logic [1:0]    ctrl_q;
    logic          locked_q;
    logic [3:0]    off_q, off_d;
    logic          lost_q, lost_d;
    logic [RW-1:0] run_q, run_d, run_inc;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic          stale_q;

    logic [19:0]   window;
    logic [9:0]    candidate;
    logic          is_tok;
    logic [1:0]    code;
    logic          tok_ok;

    assign window    = {raw_word, prev_q};
    assign candidate = window[{1'b0, off_q} +: 10];

    always_comb begin
        is_tok = 1'b1;
        code   = 2'b00;
        case (candidate)
            10'b1101010100: code = 2'b00;
            10'b0010101011: code = 2'b01;
            10'b0101010100: code = 2'b10;
            10'b1010101011: code = 2'b11;
            default:        is_tok = 1'b0;
        endcase
    end

    assign run_inc   = (run_q == RW'(LOCK_TOKENS)) ? run_q : run_q + RW'(1);
    assign timer_inc = (timer_q == TW'(TMAX)) ? timer_q : timer_q + TW'(1);
    // The window is stale for one cycle after a slip, so tokens seen then are not counted.
    assign tok_ok    = is_tok && !stale_q;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        timer_d = timer_q;
        off_d   = off_q;
        lost_d  = 1'b0;
        case (state_q)
            HUNT: begin
                timer_d = timer_inc;
                run_d   = tok_ok ? run_inc : '0;
                if (tok_ok && (run_inc == RW'(LOCK_TOKENS))) begin
                    state_d = LOCKED;
                    timer_d = '0;
                end else if (timer_q == TW'(SEARCH_CYCLES - 1)) begin
                    state_d = SLIP;
                    timer_d = '0;
                end
            end
            SLIP: begin
                off_d   = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
                run_d   = '0;
                timer_d = '0;
                state_d = HUNT;
            end
            LOCKED: begin
                run_d = is_tok ? run_inc : '0;
                if (is_tok) begin
                    timer_d = '0;
                end else if (timer_q == TW'(LOSS_CYCLES - 1)) begin
                    state_d = SLIP;
                    timer_d = '0;
                    lost_d  = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            word_q   <= '0;
            tok_q    <= 1'b0;
            ctrl_q   <= '0;
            locked_q <= 1'b0;
            off_q    <= '0;
            lost_q   <= 1'b0;
            run_q    <= '0;
            timer_q  <= '0;
            stale_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= raw_word;
            word_q   <= candidate;
            tok_q    <= is_tok;
            if (is_tok) ctrl_q <= code;
            locked_q <= (state_d == LOCKED);
            off_q    <= off_d;
            lost_q   <= lost_d;
            run_q    <= run_d;
            timer_q  <= timer_d;
            stale_q  <= (state_q == SLIP);
        end
    end

    assign aligned_word  = word_q;
    assign control_token = tok_q;
    assign ctrl          = ctrl_q;
    assign locked        = locked_q;
    assign bit_offset    = off_q;
    assign lock_lost     = lost_q;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: serial token streams injected at chosen
// phases, with hand-computed lock, slip, loss and reset expectations.
module tb_tmds_word_aligner;

    localparam int unsigned SC = 16;
    localparam int unsigned LT = 8;
    localparam int unsigned LC = 24;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] VID   = 10'b0011100011;

    logic       clk_pixel;
    logic       reset;
    logic [9:0] raw_word;
    logic [9:0] aligned_word;
    logic       control_token;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] bit_offset;
    logic       lock_lost;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned sh       = 10;
    logic [9:0]  dprev    = '0;

    tmds_word_aligner #(
        .SEARCH_CYCLES(SC),
        .LOCK_TOKENS  (LT),
        .LOSS_CYCLES  (LC)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .raw_word     (raw_word),
        .aligned_word (aligned_word),
        .control_token(control_token),
        .ctrl         (ctrl),
        .locked       (locked),
        .bit_offset   (bit_offset),
        .lock_lost    (lock_lost)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial stream of words d; injection phase P gives raw = {d, dprev}[10-P +: 10].
    task automatic step(input logic [9:0] d);
        logic [19:0] t;
        t        = {d, dprev};
        raw_word = t[sh +: 10];
        dprev    = d;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_reset(input int unsigned phase);
        reset    = 1'b1;
        raw_word = '0;
        dprev    = '0;
        sh       = 10 - phase;
        repeat (2) @(posedge clk_pixel);
        #3;
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_word"}, 32'(aligned_word), 32'd0);
        check({tag, "_tok"},  32'(control_token), 32'd0);
        check({tag, "_ctrl"}, 32'(ctrl), 32'd0);
        check({tag, "_lock"}, 32'(locked), 32'd0);
        check({tag, "_off"},  32'(bit_offset), 32'd0);
        check({tag, "_lost"}, 32'(lock_lost), 32'd0);
    endtask

    initial begin
        int unsigned n;
        int unsigned first3;

        // Reset values
        do_reset(0);
        check_zero("reset");

        // Token 00 stream at phase 3: three slips then lock at offset 3
        do_reset(3);
        n = 0;
        first3 = 0;
        while (!locked && n < 80) begin
            step(TOK00);
            n++;
            if (first3 == 0 && bit_offset == 4'd3) first3 = n;
        end
        check("t1_offset_reach", first3, 3 * (SC + 1));
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_offset", 32'(bit_offset), 32'd3);
        check("t1_word", 32'(aligned_word), 32'(TOK00));
        check("t1_ctrl", 32'(ctrl), 32'd0);
        check("t1_tok", 32'(control_token), 32'd1);

        // ctrl follows token 11, then holds through a video word
        step(TOK11);
        step(VID);
        check("ctrl_tok11_word", 32'(aligned_word), 32'(TOK11));
        check("ctrl_tok11", 32'(ctrl), 32'd3);
        step(VID);
        check("ctrl_hold_tok", 32'(control_token), 32'd0);
        check("ctrl_hold", 32'(ctrl), 32'd3);
        check("ctrl_hold_word", 32'(aligned_word), 32'(VID));

        // Keep-alive: one token every LC-2 cycles holds lock
        for (int i = 0; i < 10 * LC; i++) begin
            step((i % (LC - 2) == 0) ? TOK00 : VID);
            check("t4_locked", 32'(locked), 32'd1);
            check("t4_lost", 32'(lock_lost), 32'd0);
        end
        check("t4_offset", 32'(bit_offset), 32'd3);

        // Phase 0, 7 tokens / 1 video: never locks, slips every SC+1, wraps 9->0
        do_reset(0);
        for (int c = 1; c <= 11 * (SC + 1); c++) begin
            step((c % 8 == 0) ? VID : TOK00);
            check("t2_offset", 32'(bit_offset), 32'((c / (SC + 1)) % 10));
            check("t2_nolock", 32'(locked), 32'd0);
        end

        // Lock at phase 5, then video-only until loss
        do_reset(5);
        n = 0;
        while (!locked && n < 120) begin
            step(TOK00);
            n++;
        end
        check("t3_locked", 32'(locked), 32'd1);
        check("t3_offset", 32'(bit_offset), 32'd5);
        for (int i = 0; i < LC; i++) begin
            step(VID);
            check("t3_nolost", 32'(lock_lost), 32'd0);
        end
        check("t3_still_locked", 32'(locked), 32'd1);
        step(VID);
        check("t3_lost_pulse", 32'(lock_lost), 32'd1);
        check("t3_unlocked", 32'(locked), 32'd0);
        step(VID);
        check("t3_lost_end", 32'(lock_lost), 32'd0);
        check("t3_offset_after", 32'(bit_offset), 32'd6);
        check("t3_unlocked2", 32'(locked), 32'd0);

        // Lock on the same cycle the HUNT timer expires
        do_reset(0);
        for (int i = 1; i <= 15; i++) step((i <= 7) ? VID : TOK00);
        check("t5_prelock", 32'(locked), 32'd0);
        step(TOK00);
        check("t5_locked", 32'(locked), 32'd1);
        check("t5_offset", 32'(bit_offset), 32'd0);
        step(TOK00);
        check("t5_locked2", 32'(locked), 32'd1);
        check("t5_offset2", 32'(bit_offset), 32'd0);

        // Async reset mid-HUNT at offset 7
        do_reset(0);
        for (int i = 0; i < 7 * (SC + 1) + 6; i++) step(10'h3FF);
        check("t6_pre_offset", 32'(bit_offset), 32'd7);
        check("t6_pre_word", 32'(aligned_word), 32'h3FF);
        #2;
        reset = 1'b1;
        #1;
        check_zero("t6_async");
        do_reset(0);
        for (int i = 0; i < SC; i++) step(10'h3FF);
        check("t6_restart0", 32'(bit_offset), 32'd0);
        step(10'h3FF);
        check("t6_restart1", 32'(bit_offset), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
